life_sequencer: RTL and testbench

- Controller for the 8x8 Game of Life generation datapath.
- Owns the 64-bit grid state register and feeds it to the combinational next-generation datapath.
- Commits the datapath result on a paced tick, in free-run or single-step mode.
- Halts on a stable pattern, an extinct pattern, a generation limit, or a user stop. It replaces the ad-hoc enable logic around the grid flop.

---
 rtl/life_pkg.sv | 6 +
 rtl/tick_divider.sv | 18 +
 rtl/life_sequencer.sv | 74 +++++++
 tb/tb_life_sequencer.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// life_pkg: shared grid width, sequencer state and halt reason encodings
package life_pkg;
  localparam int GRID_W = 64;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [2:0] {NONE, STABLE, EXTINCT, LIMIT, STOPPED} halt_t;
endpackage

// File: rtl/tick_divider.sv
// tick_divider: paces free-run commits with a one-cycle pulse every TICK_DIV cycles
module tick_divider #(
  parameter int TICK_DIV = 12_500_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic run,
  output logic tick
);
  localparam int W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);
  logic [W-1:0] cnt;
  assign tick = run && cnt == LAST;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else cnt <= (clear || !run || tick) ? '0 : cnt + W'(1);
endmodule

// File: rtl/life_sequencer.sv
// life_sequencer: owns the Game of Life grid register and sequences generation commits
module life_sequencer
  import life_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int TICK_DIV = 12_500_000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [GRID_W-1:0] seed,
  input  logic              start,
  input  logic              stop,
  input  logic              step,
  input  logic [CNT_W-1:0]  max_gens,
  input  logic [GRID_W-1:0] grid_next,
  output logic [GRID_W-1:0] grid,
  output logic [CNT_W-1:0]  gen_count,
  output logic              busy,
  output logic              done,
  output logic [2:0]        halt_reason
);
  state_t state;
  halt_t halt, commit_halt;
  logic tick, same, limit, do_load, do_start, do_stop, do_commit;
  logic [CNT_W:0] gen_p1;
  logic [CNT_W-1:0] gen_inc;
  // the extra bit keeps a saturated counter from re-matching an all-ones limit
  assign gen_p1 = {1'b0, gen_count} + (CNT_W + 1)'(1);
  assign gen_inc = gen_p1[CNT_W] ? gen_count : gen_p1[CNT_W-1:0];
  assign same = grid_next == grid;
  assign limit = |max_gens && gen_p1 == {1'b0, max_gens};
  assign commit_halt = same ? STABLE : ~|grid_next ? EXTINCT : limit ? LIMIT : NONE;
  assign do_load = load && state != RUN;
  assign do_start = start && state == IDLE;
  assign do_stop = stop && state == RUN;
  assign do_commit = state == IDLE ? step : state == RUN && tick;
  assign busy = state == RUN;
  assign done = state == DONE;
  assign halt_reason = halt;
  tick_divider #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (do_start),
    .run    (busy),
    .tick   (tick)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state     <= IDLE;
      halt      <= NONE;
      grid      <= '0;
      gen_count <= '0;
    end else if (do_load) begin
      state     <= IDLE;
      halt      <= NONE;
      grid      <= seed;
      gen_count <= '0;
    end else if (do_start) begin
      state <= RUN;
    end else if (do_stop) begin
      state <= IDLE;
      halt  <= STOPPED;
    end else if (do_commit) begin
      if (!same) begin
        grid      <= grid_next;
        gen_count <= gen_inc;
      end
      if (commit_halt != NONE) begin
        state <= DONE;
        halt  <= commit_halt;
      end
    end
endmodule

// File: tb/tb_life_sequencer.sv
// tb_life_sequencer: vector table plus corner sequences against an 8x8 Life reference datapath
module tb_life_sequencer;
  localparam logic [63:0] BLINK_H = 64'h0000_0000_1C00_0000;
  localparam logic [63:0] BLINK_V = 64'h0000_0008_0808_0000;
  localparam logic [63:0] BLOCK   = 64'h0000_0018_1800_0000;
  localparam logic [63:0] SINGLE  = 64'h0000_0000_0800_0000;

  typedef struct {
    logic [63:0] grid;
    logic [15:0] gen;
    logic        busy;
    logic        done;
    logic [2:0]  halt;
  } exp_t;

  typedef struct {
    string       name;
    logic [63:0] seed;
    logic        stepm;
    logic [15:0] mg;
    int          cycles;
    exp_t        e;
  } vec_t;

  logic clk = 0, reset_n = 0, load = 0, start = 0, stop = 0, step = 0;
  logic [63:0] seed = '0, grid_next, grid;
  logic [15:0] max_gens = '0, gen_count;
  logic busy, done;
  logic [2:0] halt_reason;
  int tests = 0, fails = 0;
  exp_t sb[$];
  vec_t vecs[8];

  always #5 clk = ~clk;

  life_sequencer #(.CNT_W(16), .TICK_DIV(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (load),
    .seed       (seed),
    .start      (start),
    .stop       (stop),
    .step       (step),
    .max_gens   (max_gens),
    .grid_next  (grid_next),
    .grid       (grid),
    .gen_count  (gen_count),
    .busy       (busy),
    .done       (done),
    .halt_reason(halt_reason)
  );

  function automatic logic [63:0] life_next(input logic [63:0] g);
    logic [63:0] n;
    n = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        int k;
        k = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < 8 && c + dc >= 0 && c + dc < 8)
              k += int'(g[(r + dr) * 8 + c + dc]);
        n[r * 8 + c] = (k == 3) || (g[r * 8 + c] && k == 2);
      end
    return n;
  endfunction

  always_comb grid_next = life_next(grid);

  function automatic exp_t mk(logic [63:0] g, logic [15:0] n, logic b, logic d, logic [2:0] h);
    exp_t e;
    e.grid = g; e.gen = n; e.busy = b; e.done = d; e.halt = h;
    return e;
  endfunction

  task automatic cmp(string n, logic [63:0] a, logic [63:0] x);
    tests++;
    if (a !== x) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", n, a, x);
    end
  endtask

  task automatic check_out(string tag);
    exp_t e;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL %s: scoreboard empty, got %h, expected an entry", tag, grid);
      return;
    end
    tests--;
    e = sb.pop_front();
    cmp({tag, ".grid"}, grid, e.grid);
    cmp({tag, ".gen"}, 64'(gen_count), 64'(e.gen));
    cmp({tag, ".busy"}, 64'(busy), 64'(e.busy));
    cmp({tag, ".done"}, 64'(done), 64'(e.done));
    cmp({tag, ".halt"}, 64'(halt_reason), 64'(e.halt));
  endtask

  task automatic pulse_stop();
    @(negedge clk) stop = 1;
    @(negedge clk) stop = 0;
  endtask

  task automatic load_go(logic [63:0] s, logic [15:0] mg, logic stepm);
    @(negedge clk) begin seed = s; load = 1; max_gens = mg; end
    @(negedge clk) begin load = 0; if (stepm) step = 1; else start = 1; end
    @(negedge clk) begin step = 0; start = 0; end
  endtask

  initial begin
    vecs[0] = '{"blink_c4",  BLINK_H, 0, 16'd0, 4,  mk(BLINK_V, 1, 1, 0, 0)};
    vecs[1] = '{"blink_c8",  BLINK_H, 0, 16'd0, 8,  mk(BLINK_H, 2, 1, 0, 0)};
    vecs[2] = '{"block",     BLOCK,   0, 16'd0, 4,  mk(BLOCK, 0, 0, 1, 1)};
    vecs[3] = '{"single",    SINGLE,  1, 16'd0, 0,  mk(64'h0, 1, 0, 1, 2)};
    vecs[4] = '{"limit3",    BLINK_H, 0, 16'd3, 12, mk(BLINK_V, 3, 0, 1, 3)};
    vecs[5] = '{"zero_seed", 64'h0,   1, 16'd0, 0,  mk(64'h0, 0, 0, 1, 1)};
    vecs[6] = '{"blink_step",BLINK_H, 1, 16'd0, 0,  mk(BLINK_V, 1, 0, 0, 0)};
    vecs[7] = '{"limit1",    BLINK_H, 1, 16'd1, 0,  mk(BLINK_V, 1, 0, 1, 3)};
    repeat (2) @(negedge clk);
    sb.push_back(mk(64'h0, 0, 0, 0, 0));
    check_out("reset");
    reset_n = 1;
    for (int i = 0; i < 8; i++) begin
      if (busy) pulse_stop();
      load_go(vecs[i].seed, vecs[i].mg, vecs[i].stepm);
      sb.push_back(vecs[i].e);
      repeat (vecs[i].cycles) @(negedge clk);
      check_out(vecs[i].name);
    end
    // stop on the same edge as the second terminal tick
    load_go(BLINK_H, 16'd0, 0);
    repeat (7) @(negedge clk);
    stop = 1;
    sb.push_back(mk(BLINK_V, 1, 0, 0, 4));
    @(negedge clk) stop = 0;
    check_out("stop_collide");
    @(negedge clk) step = 1;
    sb.push_back(mk(BLINK_H, 2, 0, 0, 4));
    @(negedge clk) step = 0;
    check_out("step_after_stop");
    // async reset mid-run
    load_go(BLINK_H, 16'd0, 0);
    repeat (5) @(negedge clk);
    #2 reset_n = 0;
    sb.push_back(mk(64'h0, 0, 0, 0, 0));
    #1 check_out("async_reset");
    @(negedge clk) reset_n = 1;
    // load beats start in the same cycle
    @(negedge clk) begin seed = BLOCK; load = 1; start = 1; end
    @(negedge clk) begin load = 0; start = 0; end
    sb.push_back(mk(BLOCK, 0, 0, 0, 0));
    repeat (6) @(negedge clk);
    check_out("load_start");
    // a limit already passed is ignored, a later one still fires
    load_go(BLINK_H, 16'd0, 0);
    repeat (8) @(negedge clk);
    max_gens = 16'd1;
    sb.push_back(mk(BLINK_V, 3, 1, 0, 0));
    repeat (4) @(negedge clk);
    check_out("limit_passed");
    max_gens = 16'd4;
    sb.push_back(mk(BLINK_H, 4, 0, 1, 3));
    repeat (4) @(negedge clk);
    check_out("limit_later");
    cmp("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
